// File: rtl/dsc_mac_ctrl_pkg.sv
// Shared definitions for the stochastic MAC controller: state encoding and default widths.
package dsc_pkg;

   localparam int unsigned WA_DEF = 4;
   localparam int unsigned WC_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/dsc_mac_ctrl_if.sv
// Operand, generator-control and status bundle between the MAC controller and its environment.
interface dsc_mac_ctrl_if
   import dsc_pkg::*;
#(
   parameter int unsigned WA = WA_DEF,
   parameter int unsigned WC = WC_DEF
) ();

   logic          start;
   logic          abort;
   logic [WA-1:0] op_a;
   logic [WA-1:0] op_b;
   logic [WC-1:0] op_c;
   logic          sn_in;
   logic [WA-1:0] bin_a;
   logic [WA-1:0] bin_b;
   logic [WC-1:0] bin_c;
   logic          en_a;
   logic          en_b;
   logic          en_c;
   logic          gen_rst;
   logic          sel;
   logic          busy;
   logic          done;
   logic [WC-1:0] result;

   modport master (
      output start, abort, op_a, op_b, op_c, sn_in,
      input  bin_a, bin_b, bin_c, en_a, en_b, en_c, gen_rst, sel, busy, done, result
   );

   modport slave (
      input  start, abort, op_a, op_b, op_c, sn_in,
      output bin_a, bin_b, bin_c, en_a, en_b, en_c, gen_rst, sel, busy, done, result
   );

endinterface

// File: rtl/dsc_mac_ctrl_counter.sv
// Free-running up counter with synchronous clear and a terminal-count flag qualified by enable.
module dsc_mac_ctrl_counter #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             ovf_c
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + WIDTH'(1);
      end
   end

   assign ovf_c = en & (q == '1);

endmodule

// File: rtl/dsc_mac_ctrl.sv
// Sequencer for a stochastic scaled-add MAC: runs the bitstream generators and counts sn_in ones.
module dsc_mac_ctrl
   import dsc_pkg::*;
#(
   parameter int unsigned WA = WA_DEF,
   parameter int unsigned WC = WC_DEF
) (
   input logic          clk,
   input logic          rst,
   dsc_mac_ctrl_if.slave bus
);

   localparam int unsigned WS = 2*WA + 1;
   localparam logic [WS-1:0] LO_MASK = WS'((2**WA) - 1);

   generate
      if (WC != 2*WA) begin : g_width_chk
         $error("dsc_mac_ctrl: WC must equal 2*WA");
      end
   endgenerate

   state_e        state, state_n;
   logic [WS-1:0] seq;
   logic          last_c;
   logic          load_c;
   logic          run_c;
   logic [WC:0]   acc, acc_n, acc_inc;
   logic [WA-1:0] bin_a, bin_a_n, bin_b, bin_b_n;
   logic [WC-1:0] bin_c, bin_c_n, result, result_n;
   logic          busy, busy_n, done, done_n, gen_rst, gen_rst_n;

   assign load_c = (state == LOAD);
   assign run_c  = (state == RUN);

   dsc_mac_ctrl_counter #(.WIDTH(WS)) u_seq (
      .clk   (clk),
      .rst   (rst),
      .clr   (load_c),
      .en    (run_c),
      .q     (seq),
      .ovf_c (last_c)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      bin_a_n  = bin_a;
      bin_b_n  = bin_b;
      bin_c_n  = bin_c;
      result_n = result;
      acc_inc  = acc + (WC+1)'(bus.sn_in);

      case (state)
         IDLE, DONE: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else if (bus.start) begin
               state_n = LOAD;
               bin_a_n = bus.op_a;
               bin_b_n = bus.op_b;
               bin_c_n = bus.op_c;
            end else begin
               state_n = IDLE;
            end
         end
         LOAD: begin
            acc_n   = '0;
            state_n = bus.abort ? IDLE : RUN;
         end
         RUN: begin
            if (bus.abort) begin
               state_n = IDLE;
            end else begin
               acc_n = acc_inc;
               if (last_c) begin
                  state_n  = DONE;
                  result_n = acc_inc[WC:1];
               end
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n    = (state_n == LOAD) || (state_n == RUN);
      done_n    = (state_n == DONE);
      gen_rst_n = (state_n == LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         bin_a   <= '0;
         bin_b   <= '0;
         bin_c   <= '0;
         result  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         gen_rst <= 1'b1;
      end else begin
         state   <= state_n;
         acc     <= acc_n;
         bin_a   <= bin_a_n;
         bin_b   <= bin_b_n;
         bin_c   <= bin_c_n;
         result  <= result_n;
         busy    <= busy_n;
         done    <= done_n;
         gen_rst <= gen_rst_n;
      end
   end

   assign bus.bin_a   = bin_a;
   assign bus.bin_b   = bin_b;
   assign bus.bin_c   = bin_c;
   assign bus.result  = result;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.gen_rst = gen_rst;

   // Phase 0 (seq MSB low) walks the a/b product grid, phase 1 walks the c stream
   assign bus.en_a = run_c & ~seq[WS-1];
   assign bus.en_b = bus.en_a & ((seq | ~LO_MASK) == '1);
   assign bus.en_c = run_c & seq[WS-1];
   assign bus.sel  = run_c & seq[WS-1];

endmodule

// File: tb/tb_dsc_mac_ctrl.sv
// Directed scoreboard bench for dsc_mac_ctrl with a counter-comparator model of the sn_in datapath.
module tb_dsc_mac_ctrl;

   localparam int unsigned WA = 4;
   localparam int unsigned WC = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dsc_mac_ctrl_if #(.WA(WA), .WC(WC)) bus ();

   dsc_mac_ctrl #(.WA(WA), .WC(WC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Generator model: counters cleared by gen_rst, advanced by the strobes
   logic [WA-1:0] a_ctr, b_ctr;
   logic [WC-1:0] c_ctr;

   always @(posedge clk) begin
      if (bus.gen_rst) begin
         a_ctr <= '0;
         b_ctr <= '0;
         c_ctr <= '0;
      end else begin
         if (bus.en_a) a_ctr <= a_ctr + 1'b1;
         if (bus.en_b) b_ctr <= b_ctr + 1'b1;
         if (bus.en_c) c_ctr <= c_ctr + 1'b1;
      end
   end

   assign bus.sn_in = bus.sel ? (c_ctr < bus.bin_c)
                              : ((a_ctr < bus.bin_a) && (b_ctr < bus.bin_b));

   int   enb_rise  = 0;
   int   enc_high  = 0;
   int   done_seen = 0;
   logic enb_prev  = 1'b0;

   always @(posedge clk) begin
      enb_prev <= bus.en_b;
      if (bus.gen_rst) begin
         enb_rise <= 0;
         enc_high <= 0;
      end else begin
         if (bus.en_b && !enb_prev && !bus.sel) enb_rise <= enb_rise + 1;
         if (bus.en_c) enc_high <= enc_high + 1;
      end
      if (bus.done) done_seen <= done_seen + 1;
   end

   int            checks = 0;
   int            errors = 0;
   logic [WC-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int a, input int b, input int c);
      bus.op_a  = WA'(a);
      bus.op_b  = WB_cast(b);
      bus.op_c  = WC'(c);
      bus.start = 1'b1;
      exp_q.push_back(WC'((a*b + c) / 2));
      step();
   endtask

   function automatic logic [WA-1:0] WB_cast(input int v);
      return WA'(v);
   endfunction

   task automatic wait_done(input string tag, input int poke_at, input logic [WA-1:0] a_lat);
      int n  = 1;
      int bc = 1;
      bit got = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (poke_at > 0 && n == poke_at) begin
            bus.start = 1'b1;
            bus.op_a  = ~a_lat;
         end
         step();
         n++;
         if (poke_at > 0 && n == poke_at + 1) bus.start = 1'b0;
         if (bus.busy) bc++;
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(got), 1);
      if (got) begin
         check({tag, "_done_latency"}, n, 514);
         check({tag, "_busy_cycles"}, bc, 513);
         check({tag, "_enb_rises"}, enb_rise, 16);
         check({tag, "_enc_high"}, enc_high, 256);
         check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check({tag, "_result"}, bus.result, exp_q.pop_front());
         if (poke_at > 0) check({tag, "_bin_a_kept"}, bus.bin_a, a_lat);
      end
   endtask

   int done_before;

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.op_c  = '0;
      repeat (3) step();

      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_gen_rst", bus.gen_rst, 1);
      check("rst_bin_a", bus.bin_a, 0);
      check("rst_bin_c", bus.bin_c, 0);
      check("rst_en_a", bus.en_a, 0);
      check("rst_en_c", bus.en_c, 0);
      check("rst_sel", bus.sel, 0);

      rst = 1'b0;
      step();
      check("idle_gen_rst", bus.gen_rst, 0);
      check("idle_busy", bus.busy, 0);

      // Basic operation 5*2+50
      start_op(5, 2, 50);
      bus.start = 1'b0;
      check("op1_load_busy", bus.busy, 1);
      check("op1_load_gen_rst", bus.gen_rst, 1);
      check("op1_bin_a", bus.bin_a, 5);
      check("op1_bin_c", bus.bin_c, 50);
      wait_done("op1", 0, 4'd5);
      step();
      check("op1_done_pulse", bus.done, 0);
      check("op1_result_hold", bus.result, 30);
      check("op1_idle_busy", bus.busy, 0);

      start_op(0, 0, 0);
      bus.start = 1'b0;
      wait_done("op_zero", 0, 4'd0);
      step();

      // Full-scale operands, with a start poke during RUN that must be ignored
      start_op(15, 15, 255);
      bus.start = 1'b0;
      wait_done("op_max", 200, 4'd15);
      bus.op_a = 4'd15;
      step();

      // Abort at RUN cycle 100
      bus.op_a  = 4'd7;
      bus.op_b  = 4'd3;
      bus.op_c  = 8'd20;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      repeat (100) step();
      bus.abort = 1'b1;
      done_before = done_seen;
      step();
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_en_a", bus.en_a, 0);
      check("abort_en_b", bus.en_b, 0);
      check("abort_en_c", bus.en_c, 0);
      check("abort_sel", bus.sel, 0);
      check("abort_result", bus.result, 240);
      repeat (5) step();
      check("abort_no_done", done_seen, done_before);

      // Abort beats start in IDLE
      bus.abort = 1'b1;
      bus.start = 1'b1;
      bus.op_a  = 4'd1;
      step();
      check("abort_start_busy", bus.busy, 0);
      check("abort_start_gen_rst", bus.gen_rst, 0);
      check("abort_start_bin_a", bus.bin_a, 7);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      step();

      // Reset at RUN cycle 300
      bus.op_a  = 4'd9;
      bus.op_b  = 4'd9;
      bus.op_c  = 8'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      repeat (300) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      check("mrst_result", bus.result, 0);
      check("mrst_gen_rst", bus.gen_rst, 1);
      check("mrst_bin_a", bus.bin_a, 0);
      check("mrst_bin_b", bus.bin_b, 0);
      check("mrst_bin_c", bus.bin_c, 0);
      check("mrst_en_a", bus.en_a, 0);
      check("mrst_en_c", bus.en_c, 0);
      check("mrst_sel", bus.sel, 0);
      step();
      check("mrst_gen_rst_rel", bus.gen_rst, 0);

      // Back-to-back with start held through DONE
      start_op(5, 2, 50);
      wait_done("b2b1", 0, 4'd5);
      start_op(3, 4, 10);
      check("b2b_load_busy", bus.busy, 1);
      check("b2b_load_gen_rst", bus.gen_rst, 1);
      check("b2b_bin_a", bus.bin_a, 3);
      check("b2b_result_hold", bus.result, 30);
      bus.start = 1'b0;
      wait_done("b2b2", 0, 4'd3);

      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
